mux_rr_sequencer: RTL and testbench
===================================

// Module: mux_rr_sequencer
// PURPOSE
// - Upstream control stage for mux_param: scans N_CH request lines round-robin and drives mux_param.sel.
// - Captures the selected mux output into a holding register and presents it downstream with a valid/ready handshake.
// - Acknowledges the served channel with a one-cycle pulse so the requester can retire its word.
// PARAMETERS
// - WIDTH  8  data width of the mux_param output
// - N_CH   4  number of channels; a power of 2, >=2
// - SEL_W  $clog2(N_CH)  width of sel; derived, never overridden
// PORTS
// - clk        in   1          single clock; all state updates on the rising edge
// - rst_n      in   1          asynchronous, active-low reset
// - req        in   N_CH       per-channel request, level-sensitive
// - ack        out  N_CH       one-hot, one-cycle pulse to the channel whose word was captured
// - sel        out  SEL_W      select driven to mux_param.sel
// - mux_out    in   WIDTH      driven from mux_param.out; combinational function of sel
// - out_data   out  WIDTH      captured word
// - out_valid  out  1          out_data valid
// - out_ready  in   1          downstream accepts out_data
// - out_ch     out  SEL_W      channel index of out_data
// BEHAVIOUR
// - Reset (asynchronous, while rst_n=0):
//   - sel=0, out_data=0, out_valid=0, out_ch=0, ack=0.
//   - Round-robin pointer ptr=0; state=IDLE.
// - FSM states: IDLE, SELECT, HOLD.
// - IDLE:
//   - If |req=0, stay in IDLE.
//   - Otherwise take grant = first set bit of req, searching upward from ptr and wrapping N_CH-1 -> 0.
//   - sel<=grant; go to SELECT.
// - SELECT (mux settles within this cycle):
//   - out_data<=mux_out, out_ch<=sel, out_valid<=1, ack[sel]<=1 for exactly one cycle.
//   - Go to HOLD.
// - HOLD:
//   - out_data, out_ch and sel are stable.
//   - When out_valid && out_ready: out_valid<=0, ptr<=(out_ch+1) mod N_CH, go to IDLE.
//   - Otherwise stay in HOLD.
// - Timing:
//   - Latency req->out_valid: 2 cycles.
//   - Peak throughput: 1 word per 3 cycles with out_ready held at 1.
// - Requests:
//   - req is sampled only in IDLE.
//   - Deassertion of req during SELECT/HOLD does not cancel the capture.
// - Round-robin wrap: ptr=N_CH-1 searches N_CH-1, 0, 1, ...
// - Fairness: with all req set, grants cycle 0,1,...,N_CH-1,0.
// - out_ready=1 in IDLE or SELECT has no effect.
// - Reset mid-operation: all outputs return to reset values immediately; any in-flight word is dropped and not acked.
// - ack is one-hot or zero; never more than one bit set.
// CONFIGURATION
// - MUX_SEQ_FIXED_PRIO_EN defined:
//   - Grant is always the lowest-index set req bit.
//   - ptr is held at 0 and never updated.
// - MUX_SEQ_FIXED_PRIO_EN undefined (default): round-robin as described above.
// TESTING
// - Reset: rst_n=0 with req=4'b1111 -> sel=0, out_valid=0, ack=0 throughout.
// - Single request: req=4'b0100, mux_out=8'h32 when sel=2, out_ready=1
//   -> sel=2 one cycle after req; out_valid=1, out_data=8'h32, out_ch=2, ack=4'b0100 two cycles after req.
// - Round-robin: req=4'b1111, out_ready=1 -> out_ch sequence 0,1,2,3,0; one word every 3 cycles.
//   - With MUX_SEQ_FIXED_PRIO_EN the sequence is 0,0,0,0.
// - Backpressure: out_ready=0 for 5 cycles after out_valid
//   -> out_data and sel stable, no new ack; handshake on out_ready=1, then IDLE.
// - Wrap: ptr=3, req=4'b0011 -> grant 0, next grant 1.
// - Reset mid-HOLD: rst_n pulsed low while out_valid=1
//   -> out_valid=0 asynchronously; after release, the first grant is channel 0.

Source files
------------

// File: rtl/mux_rr_sequencer.sv
// ---------------------------------------------------------------------------
// mux_rr_sequencer
//
// Upstream control stage for mux_param. It scans N_CH level-sensitive request
// lines round-robin, drives the mux select, captures the selected mux output
// into a holding register, and presents that word downstream with a
// valid/ready handshake. The served channel receives a one-cycle ack pulse so
// the requester can retire its word.
//
// Configuration macro:
//   MUX_SEQ_FIXED_PRIO_EN - when defined, the grant is always the lowest-index
//                           set request bit, and the round-robin pointer is
//                           held at 0.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   N_CH   per-channel request, level-sensitive
//   ack        out  N_CH   one-hot, one-cycle pulse to the served channel
//   sel        out  SEL_W  select driven to mux_param.sel
//   mux_out    in   WIDTH  mux_param.out, a combinational function of sel
//   out_data   out  WIDTH  captured word
//   out_valid  out  1      out_data valid
//   out_ready  in   1      downstream accepts out_data
//   out_ch     out  SEL_W  channel index of out_data
// ---------------------------------------------------------------------------
module mux_rr_sequencer #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            req,
  output logic [N_CH-1:0]            ack,
  output logic [$clog2(N_CH)-1:0]    sel,
  input  logic [WIDTH-1:0]           mux_out,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_CH)-1:0]    out_ch
);

  localparam int SEL_W = $clog2(N_CH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]       state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] out_ch_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [N_CH-1:0]  ack_r;
  logic [SEL_W-1:0] grant_s;

  // First set request bit at or above base, wrapping N_CH-1 -> 0. N_CH is a
  // power of two, so the SEL_W-bit addition wraps modulo N_CH by itself.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                               input logic [SEL_W-1:0] base);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = base;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = base + SEL_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // Grant search. With fixed priority the pointer never leaves 0, so the same
  // search yields the lowest-index set bit.
  always_comb begin
    grant_s = rr_pick(req, ptr_r);
  end

  // Sequencer FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= {SEL_W{1'b0}};
      sel_r       <= {SEL_W{1'b0}};
      out_ch_r    <= {SEL_W{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      ack_r       <= {N_CH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= {N_CH{1'b0}};
          if (|req) begin
            sel_r   <= grant_s;
            state_r <= SELECT;
          end else begin
            state_r <= IDLE;
          end
        end
        SELECT: begin
          // The mux has had the whole cycle to settle on sel_r.
          out_data_r  <= mux_out;
          out_ch_r    <= sel_r;
          out_valid_r <= 1'b1;
          ack_r       <= {{(N_CH-1){1'b0}}, 1'b1} << sel_r;
          state_r     <= HOLD;
        end
        HOLD: begin
          ack_r <= {N_CH{1'b0}};
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
`ifdef MUX_SEQ_FIXED_PRIO_EN
            ptr_r       <= {SEL_W{1'b0}};
`else
            ptr_r       <= out_ch_r + {{(SEL_W-1){1'b0}}, 1'b1};
`endif
            state_r     <= IDLE;
          end else begin
            state_r     <= HOLD;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          ack_r       <= {N_CH{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_r;
  assign out_ch    = out_ch_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign ack       = ack_r;

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_sequencer
//
// Directed bench for mux_rr_sequencer (WIDTH=8, N_CH=4). A small table stands
// in for mux_param: mux_out = tbl[sel]. Expected values are hand-derived.
// Honours MUX_SEQ_FIXED_PRIO_EN for the grant-order expectations.
// ---------------------------------------------------------------------------
module tb_mux_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] sel;
  logic [7:0] mux_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;

  int n_pass;
  int n_fail;
  int n_total;

  logic [7:0] tbl [4];

  assign mux_out = tbl[sel];

  mux_rr_sequencer #(.WIDTH(8), .N_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready=1: grant, capture, handshake.
  task automatic serve(input string tag, input logic [3:0] r, input logic [1:0] ch);
    logic [3:0] one_hot;
    one_hot   = 4'b0001 << ch;
    req       = r;
    out_ready = 1'b1;
    tick();
    chk({tag, "_sel"}, 32'(sel), 32'(ch));
    chk({tag, "_valid0"}, 32'(out_valid), 32'd0);
    chk({tag, "_ack0"}, 32'(ack), 32'd0);
    req = 4'b0000;
    tick();
    chk({tag, "_valid1"}, 32'(out_valid), 32'd1);
    chk({tag, "_ch"}, 32'(out_ch), 32'(ch));
    chk({tag, "_data"}, 32'(out_data), 32'(tbl[ch]));
    chk({tag, "_ack"}, 32'(ack), 32'(one_hot));
    tick();
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_ack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_ch;
    logic [3:0] exp_ack;
    n_pass    = 0;
    n_fail    = 0;
    n_total   = 0;
    tbl[0]    = 8'h10;
    tbl[1]    = 8'h21;
    tbl[2]    = 8'h32;
    tbl[3]    = 8'h43;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b0;

    // Reset holds everything idle even with all requests raised.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
    end
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    req = 4'b0000;
    #2 rst_n = 1'b1;
    tick();

    // Single request on channel 2.
    serve("single", 4'b0100, 2'd2);

    // Fresh reset, then all requests with out_ready high.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
`ifdef MUX_SEQ_FIXED_PRIO_EN
      exp_ch = 2'd0;
`else
      exp_ch = 2'((c - 1) / 3);
`endif
      exp_ack = 4'b0001 << exp_ch;
      if (c % 3 == 1) begin
        chk("rr_sel", 32'(sel), 32'(exp_ch));
        chk("rr_valid0", 32'(out_valid), 32'd0);
      end else if (c % 3 == 2) begin
        chk("rr_valid1", 32'(out_valid), 32'd1);
        chk("rr_ch", 32'(out_ch), 32'(exp_ch));
        chk("rr_data", 32'(out_data), 32'(tbl[exp_ch]));
        chk("rr_ack", 32'(ack), 32'(exp_ack));
      end else begin
        chk("rr_idle_valid", 32'(out_valid), 32'd0);
        chk("rr_idle_ack", 32'(ack), 32'd0);
      end
    end
    req = 4'b0000;
    tick();
    chk("rr_quiet_valid", 32'(out_valid), 32'd0);

    // Backpressure on channel 1; request dropped after it was sampled.
    req       = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk("bp_sel", 32'(sel), 32'd1);
    req = 4'b0000;
    tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_ack", 32'(ack), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h21);
      chk("bp_hold_sel", 32'(sel), 32'd1);
      chk("bp_hold_ch", 32'(out_ch), 32'd1);
      chk("bp_hold_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Wrap: serve channel 2 so the pointer lands on 3, then request 0 and 1.
    serve("wrap_pre", 4'b0100, 2'd2);
    serve("wrap_first", 4'b0011, 2'd0);
`ifdef MUX_SEQ_FIXED_PRIO_EN
    serve("wrap_second", 4'b0011, 2'd0);
`else
    serve("wrap_second", 4'b0011, 2'd1);
`endif

    // Reset while a word is held: dropped immediately, first grant is 0.
    req       = 4'b0100;
    out_ready = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_sel", 32'(sel), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    chk("mid_data", 32'(out_data), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    serve("post_rst", 4'b1111, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
